// File: rtl/taintcell_fifo.sv
// taintcell_fifo: show-ahead FIFO that carries per-bit taint alongside data and tracks pointer/occupancy taint
module taintcell_fifo #(
    parameter int    WIDTH     = 64,
    parameter int    DEPTH     = 8,
    parameter int    ABITS     = 3,
    parameter string CTRL_MODE = "precise"
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic             PUSH,
    input  logic             PUSH_taint,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [WIDTH-1:0] WDATA_taint,
    input  logic             POP,
    input  logic             POP_taint,
    input  logic             CLEAR_TAINT,
    output logic [WIDTH-1:0] RDATA,
    output logic [WIDTH-1:0] RDATA_taint,
    output logic             FULL,
    output logic             EMPTY,
    output logic [ABITS:0]   COUNT,
    output logic             PTR_taint,
    output logic [ABITS:0]   taint_sum
);

    localparam bit CONS = (CTRL_MODE == "conservative");

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] tmem [DEPTH];
    logic [ABITS-1:0] wr_ptr, rd_ptr;
    logic [ABITS:0]   cnt, cnt_n;
    logic             ptr_t, do_push, do_pop, ptr_set;
    logic [WIDTH-1:0] new_t;

    assign FULL        = cnt == (ABITS+1)'(DEPTH);
    assign EMPTY       = cnt == '0;
    assign COUNT       = cnt;
    assign PTR_taint   = ptr_t;
    assign RDATA       = mem[rd_ptr];
    assign RDATA_taint = EMPTY ? '0 : tmem[rd_ptr] | {WIDTH{ptr_t}};

    // Acceptance, next occupancy and the taint a newly pushed entry will carry
    always_comb begin
        do_pop  = POP & ~EMPTY;
        do_push = PUSH & (~FULL | do_pop);
        ptr_set = (PUSH & PUSH_taint) | (POP & POP_taint);
        cnt_n   = cnt + (ABITS+1)'(do_push) - (ABITS+1)'(do_pop);
        new_t   = CLEAR_TAINT ? '0 :
                  CONS        ? WDATA_taint | {WIDTH{PUSH_taint}} :
                                WDATA_taint | ({WIDTH{PUSH_taint}} & WDATA);
    end

    // Count occupied entries (walking from the head) whose taint is nonzero
    always_comb begin
        taint_sum = '0;
        for (int i = 0; i < DEPTH; i++)
            taint_sum = taint_sum + (ABITS+1)'(((ABITS+1)'(i) < cnt) && (|tmem[rd_ptr + ABITS'(i)]));
    end

    // Pointers, occupancy and all taint state; reset discards every entry
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ptr_t  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                tmem[i] <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_n;
            ptr_t <= CLEAR_TAINT ? 1'b0 : ptr_set ? 1'b1 : (cnt_n == '0) ? 1'b0 : ptr_t;
            if (CLEAR_TAINT)
                for (int i = 0; i < DEPTH; i++)
                    tmem[i] <= '0;
            if (do_push)
                tmem[wr_ptr] <= new_t;
        end
    end

    // Entry data storage is deliberately left unreset
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= WDATA;
    end

endmodule

// File: doc/taintcell_fifo.md
TAINTCELL_FIFO -- requirements
Module: taintcell_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data and taint width per entry.
REQ-002 SHALL have parameter DEPTH, default 8: entry count, power of two, >= 2.
REQ-003 SHALL have parameter ABITS, default 3: log2(DEPTH).
REQ-004 SHALL have parameter CTRL_MODE, default "precise": "precise" or "conservative" control-taint policy.
REQ-005 SHALL have port CLK  input  1: sole clock, rising edge.
REQ-006 SHALL have port ARST_N  input  1: reset; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port PUSH / PUSH_taint  input  1 / 1: write request and its taint.
REQ-008 SHALL have port WDATA / WDATA_taint  input  WIDTH / WIDTH: write data and its taint.
REQ-009 SHALL have port POP / POP_taint  input  1 / 1: read request and its taint.
REQ-010 SHALL have port CLEAR_TAINT  input  1: synchronous wipe of all taint state; data is untouched.
REQ-011 SHALL have port RDATA / RDATA_taint  output  WIDTH / WIDTH: head entry, show-ahead, and its taint.
REQ-012 SHALL have port FULL, EMPTY  output  1 each: occupancy flags.
REQ-013 SHALL have port COUNT  output  ABITS+1: occupancy, 0..DEPTH.
REQ-014 SHALL have port PTR_taint  output  1: sticky pointer/occupancy taint.
REQ-015 SHALL have port taint_sum  output  ABITS+1: number of valid entries with any taint bit set.

Function
REQ-016 Push is accepted when PUSH=1 and (FULL=0, or POP is accepted in the same cycle); pop is accepted when POP=1 and EMPTY=0.
REQ-017 An accepted push writes WDATA at wr_ptr and advances wr_ptr modulo DEPTH; an accepted pop advances rd_ptr modulo DEPTH.
REQ-018 Pointers wrap from DEPTH-1 to 0; COUNT is +1 on push only, -1 on pop only, and unchanged on push+pop.
REQ-019 Push on FULL without a pop is dropped: no state change except REQ-022.
REQ-020 Pop on EMPTY is ignored; simultaneous push and pop on EMPTY accepts the push only.
REQ-021 Stored entry taint on an accepted push:
- "precise": WDATA_taint | ({WIDTH{PUSH_taint}} & WDATA).
- "conservative": WDATA_taint | {WIDTH{PUSH_taint}}.
REQ-022 PTR_taint is set by:
- PUSH_taint=1 when PUSH=1 (accepted or dropped), or
- POP_taint=1 when POP=1 (accepted or ignored).
It clears when COUNT reaches 0 with no set condition in that cycle, or on CLEAR_TAINT.
REQ-023 RDATA = mem[rd_ptr], combinational; data pushed in cycle N is visible in cycle N+1 when the FIFO was empty.
REQ-024 RDATA_taint = taint[rd_ptr] | {WIDTH{PTR_taint}} when EMPTY=0; all zeros when EMPTY=1.
REQ-025 taint_sum counts only occupied entries (rd_ptr up to COUNT entries) with nonzero taint; it updates the cycle after the causing edge.
REQ-026 CLEAR_TAINT zeroes all entry taint and PTR_taint at the edge.
- CLEAR_TAINT wins over a set in the same cycle.
- A push taking effect in the same cycle stores zero taint.
REQ-027 No X propagation from taint: control/data inputs that are X are treated as 0 in taint equations.

Reset
REQ-028 ARST_N=0 asynchronously forces wr_ptr=rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, PTR_taint=0, taint_sum=0, RDATA_taint=0, and all entry taint=0.
REQ-029 Entry data is not reset; RDATA value while EMPTY=1 is don't-care.
REQ-030 Reset deassertion is synchronised externally; the first accepted push may occur on the first rising edge after ARST_N=1.
REQ-031 Reset asserted mid-operation discards all entries, with no partial update on that edge.

Verification
REQ-032 WIDTH=8, DEPTH=4: push 0xA5 with WDATA_taint=0x0F -> next cycle RDATA=0xA5, RDATA_taint=0x0F, COUNT=1, taint_sum=1.
REQ-033 Fill 4 clean entries then push+pop on FULL -> COUNT stays 4, head advances, new entry stored at wrapped wr_ptr=0; a further push without pop is dropped.
REQ-034 "precise", push WDATA=0x3C with PUSH_taint=1 -> entry taint 0x3C and PTR_taint=1; pop all entries -> PTR_taint clears when COUNT=0; repeat in "conservative" -> entry taint 0xFF.
REQ-035 POP_taint=1 with POP=1 on EMPTY -> PTR_taint=1, COUNT=0, RDATA_taint=0; next push -> RDATA_taint=0xFF.
REQ-036 3 tainted entries, CLEAR_TAINT with a simultaneous tainted push -> taint_sum=0, PTR_taint=0, COUNT=4, data intact.
REQ-037 ARST_N pulsed low mid-cycle with COUNT=3 -> immediately EMPTY=1, COUNT=0, taint_sum=0, with no clock edge required.
